// File: rtl/clk_gate_mode_ctrl.sv
// Multi-channel gated clock root with glitch-free per-channel polarity switching.
// Macros: CLK_MODE_SW_SWITCH_CNT_EN adds per-channel switch counters; FPGA / SIM_CLK select the clock output path.

module icg (
  input  logic i_ck,
  input  logic i_e,
  input  logic i_te,
  output logic o_q
);
  logic r_en_lat;

  always_latch begin
    if (!i_ck) r_en_lat <= i_e | i_te;
  end

  assign o_q = i_ck & r_en_lat;
endmodule

module clk_inv (
  input  logic i_a,
  output logic o_y
);
  assign o_y = ~i_a;
endmodule

module clk_mux (
  input  logic i_a0,
  input  logic i_a1,
  input  logic i_s,
  output logic o_y
);
  assign o_y = i_s ? i_a1 : i_a0;
endmodule

module clk_gate_mode_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int RST_EN_VAL  = 1
) (
  input  logic              rstn,
  input  logic              i_clk_ref,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic [NUM_CH-1:0] i_ch_mode,
  output logic [NUM_CH-1:0] o_clk_ch,
  output logic [NUM_CH-1:0] o_ch_active,
  output logic [NUM_CH-1:0] o_ch_busy,
  output logic [NUM_CH-1:0] o_ch_mode_applied
`ifdef CLK_MODE_SW_SWITCH_CNT_EN
  ,
  output logic [NUM_CH*8-1:0] o_ch_sw_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic       RST_EN    = (RST_EN_VAL != 0);
  localparam state_t     RST_STATE = RST_EN ? ST_RUN : ST_IDLE;
  localparam logic [7:0] CNT_LOAD  = 8'(SETTLE_CYC - 1);

`ifdef CLK_MODE_SW_SWITCH_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  logic [NUM_CH-1:0] r_en_sync   [SYNC_STAGES];
  logic [NUM_CH-1:0] r_mode_sync [SYNC_STAGES];
  logic [NUM_CH-1:0] w_en_s;
  logic [NUM_CH-1:0] w_mode_s;

  // Synchroniser stages: index 0 faces the asynchronous config bits
  always_ff @(posedge i_clk_ref or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_en_sync[i]   <= {NUM_CH{RST_EN}};
        r_mode_sync[i] <= '0;
      end
    end else begin
      r_en_sync[0]   <= i_ch_en;
      r_mode_sync[0] <= i_ch_mode;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_en_sync[i]   <= r_en_sync[i-1];
        r_mode_sync[i] <= r_mode_sync[i-1];
      end
    end
  end

  assign w_en_s   = r_en_sync[SYNC_STAGES-1];
  assign w_mode_s = r_mode_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_mode_app;
    logic       w_mode_app_nxt;
    logic       r_active;
    logic       r_busy;

    always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_mode_app_nxt = r_mode_app;
      case (r_state)
        ST_IDLE: begin
          // Clock is stopped, so the mux select may follow the input freely
          w_mode_app_nxt = w_mode_s[g];
          if (w_en_s[g]) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!w_en_s[g]) begin
            w_state_nxt = ST_IDLE;
          end else if (w_mode_s[g] != r_mode_app) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == 8'd0) begin
            w_mode_app_nxt = w_mode_s[g];
            w_cnt_nxt      = CNT_LOAD;
            w_state_nxt    = ST_SETTLE;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        ST_SETTLE: begin
          // A disable seen mid-sequence only takes effect here, never as an abort
          if (r_cnt == 8'd0) begin
            w_state_nxt = w_en_s[g] ? ST_RUN : ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge i_clk_ref or negedge rstn) begin
      if (!rstn) begin
        r_state    <= RST_STATE;
        r_cnt      <= 8'd0;
        r_mode_app <= 1'b0;
        r_active   <= RST_EN;
        r_busy     <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_cnt      <= w_cnt_nxt;
        r_mode_app <= w_mode_app_nxt;
        r_active   <= (w_state_nxt == ST_RUN);
        r_busy     <= (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_SETTLE);
      end
    end

    assign o_ch_active[g]       = r_active;
    assign o_ch_busy[g]         = r_busy;
    assign o_ch_mode_applied[g] = r_mode_app;

`ifdef CLK_MODE_SW_SWITCH_CNT_EN
    logic [7:0] r_sw_cnt;
    logic       w_sw_inc;

    assign w_sw_inc = (r_state == ST_DRAIN) && (r_cnt == 8'd0) && (w_mode_s[g] != r_mode_app);

    always_ff @(posedge i_clk_ref or negedge rstn) begin
      if (!rstn)         r_sw_cnt <= 8'd0;
      else if (w_sw_inc) r_sw_cnt <= sat_inc8(r_sw_cnt);
    end

    assign o_ch_sw_cnt[g*8 +: 8] = r_sw_cnt;
`endif

    // Output clock path: gate, then polarity select
`ifdef FPGA
    assign o_clk_ch[g] = i_clk_ref;
`elsif SIM_CLK
    logic r_gate_lat;
    logic w_gclk;

    always_latch begin
      if (!i_clk_ref) r_gate_lat <= r_active;
    end

    assign w_gclk      = i_clk_ref & r_gate_lat;
    assign o_clk_ch[g] = r_mode_app ? ~w_gclk : w_gclk;
`else
    logic w_gclk;
    logic w_gclk_n;

    icg u_icg (
      .i_ck (i_clk_ref),
      .i_e  (r_active),
      .i_te (1'b0),
      .o_q  (w_gclk)
    );

    clk_inv u_inv (
      .i_a (w_gclk),
      .o_y (w_gclk_n)
    );

    clk_mux u_mux (
      .i_a0 (w_gclk),
      .i_a1 (w_gclk_n),
      .i_s  (r_mode_app),
      .o_y  (o_clk_ch[g])
    );
`endif
  end

endmodule

// File: tb/tb_clk_gate_mode_ctrl.sv
// Directed bench for clk_gate_mode_ctrl with a cycle-level reference model and per-cycle compare.
module tb_clk_gate_mode_ctrl;

  localparam int NCH = 2;
  localparam int SS  = 2;
  localparam int SC  = 4;

  logic           rstn;
  logic           clk;
  logic [NCH-1:0] en;
  logic [NCH-1:0] mode;
  logic [NCH-1:0] o_clk;
  logic [NCH-1:0] o_act;
  logic [NCH-1:0] o_busy;
  logic [NCH-1:0] o_mapp;
`ifdef CLK_MODE_SW_SWITCH_CNT_EN
  logic [NCH*8-1:0] o_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 0;

  // Reference model: the async inputs appear SS cycles late; a mode change
  // costs 2*SC gated cycles with the new mode sampled at the halfway point.
  logic [SS-1:0] m_sen [NCH];
  logic [SS-1:0] m_smd [NCH];
  int            m_left [NCH];
  bit            m_act  [NCH];
  bit            m_actp [NCH];
  bit            m_app  [NCH];
  int            m_cnt  [NCH];

  clk_gate_mode_ctrl #(
    .NUM_CH      (NCH),
    .SYNC_STAGES (SS),
    .SETTLE_CYC  (SC),
    .RST_EN_VAL  (1)
  ) dut (
    .rstn              (rstn),
    .i_clk_ref         (clk),
    .i_ch_en           (en),
    .i_ch_mode         (mode),
    .o_clk_ch          (o_clk),
    .o_ch_active       (o_act),
    .o_ch_busy         (o_busy),
    .o_ch_mode_applied (o_mapp)
`ifdef CLK_MODE_SW_SWITCH_CNT_EN
    ,
    .o_ch_sw_cnt       (o_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sen[c]  = '1;
      m_smd[c]  = '0;
      m_left[c] = 0;
      m_act[c]  = 1'b1;
      m_actp[c] = 1'b1;
      m_app[c]  = 1'b0;
      m_cnt[c]  = 0;
    end
  endtask

  task automatic model_step();
    bit es;
    bit ms;
    for (int c = 0; c < NCH; c++) begin
      es = m_sen[c][SS-1];
      ms = m_smd[c][SS-1];
      m_actp[c] = m_act[c];
      if (m_left[c] > 0) begin
        m_left[c]--;
        if (m_left[c] == SC) begin
          if (ms != m_app[c] && m_cnt[c] < 255) m_cnt[c]++;
          m_app[c] = ms;
        end
        if (m_left[c] == 0) m_act[c] = es;
      end else if (m_act[c]) begin
        if (!es) begin
          m_act[c] = 1'b0;
        end else if (ms != m_app[c]) begin
          m_left[c] = 2 * SC;
          m_act[c]  = 1'b0;
        end
      end else begin
        m_app[c] = ms;
        if (es) m_act[c] = 1'b1;
      end
      m_sen[c] = {m_sen[c][SS-2:0], en[c]};
      m_smd[c] = {m_smd[c][SS-2:0], mode[c]};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else       model_step();
    end
  end

  // Per-cycle compare: status and clock in the high phase, clock again in the low phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_on) begin
        for (int c = 0; c < NCH; c++) begin
          chk($sformatf("active[%0d]", c), o_act[c], m_act[c]);
          chk($sformatf("busy[%0d]", c), o_busy[c], (m_left[c] != 0));
          chk($sformatf("mode_applied[%0d]", c), o_mapp[c], m_app[c]);
          chk($sformatf("clk_hi[%0d]", c), o_clk[c], m_app[c] ^ m_actp[c]);
`ifdef CLK_MODE_SW_SWITCH_CNT_EN
          chk($sformatf("sw_cnt[%0d]", c), o_cnt[c*8 +: 8], m_cnt[c]);
`endif
        end
      end
      @(negedge clk);
      #1;
      if (chk_on) begin
        for (int c = 0; c < NCH; c++)
          chk($sformatf("clk_lo[%0d]", c), o_clk[c], m_app[c]);
      end
    end
  end

  // Edge k occurs at time 10k-5; this lands 2 time units after it
  task automatic go_edge(input int k);
    while ($time < 10 * k - 3) #1;
  endtask

  initial begin
    rstn = 1'b0;
    en   = 2'b11;
    mode = 2'b00;
    go_edge(5);
    #3 rstn = 1'b1;
    chk_on = 1'b1;

    go_edge(8);
    chk("rst_active", o_act, 3);
    chk("rst_busy", o_busy, 0);
    chk("rst_mapp", o_mapp, 0);
    chk("rst_clk_hi", o_clk, 3);
    #5 chk("rst_clk_lo", o_clk, 0);

    go_edge(10); en[0] = 1'b0;
    go_edge(12); chk("dis_act0_e12", o_act[0], 1);
    go_edge(13); chk("dis_act0_e13", o_act[0], 0);
                 chk("dis_act1_e13", o_act[1], 1);
                 chk("dis_clk0_e13", o_clk[0], 1);
    go_edge(14); chk("dis_clk0_e14", o_clk[0], 0);

    go_edge(20); mode[1] = 1'b1;
    go_edge(22); chk("sw_busy1_e22", o_busy[1], 0);
    go_edge(23); chk("sw_busy1_e23", o_busy[1], 1);
                 chk("sw_act1_e23", o_act[1], 0);
    go_edge(24); chk("sw_clk1_e24", o_clk[1], 0);
    go_edge(26); chk("sw_mapp1_e26", o_mapp[1], 0);
    go_edge(27); chk("sw_mapp1_e27", o_mapp[1], 1);
    go_edge(30); chk("sw_busy1_e30", o_busy[1], 1);
    go_edge(31); chk("sw_busy1_e31", o_busy[1], 0);
                 chk("sw_act1_e31", o_act[1], 1);
    go_edge(32); chk("sw_clk1_e32", o_clk[1], 0);
`ifdef CLK_MODE_SW_SWITCH_CNT_EN
                 chk("sw_cnt1_e32", o_cnt[15:8], 1);
`endif

    go_edge(35); mode[1] = 1'b0;
    go_edge(42); chk("back_mapp1_e42", o_mapp[1], 0);
    go_edge(46); chk("back_busy1_e46", o_busy[1], 0);

    go_edge(50); mode[1] = 1'b1;
    go_edge(52); mode[1] = 1'b0;
    go_edge(53); chk("rev_busy1_e53", o_busy[1], 1);
    go_edge(57); chk("rev_mapp1_e57", o_mapp[1], 0);
    go_edge(60); chk("rev_busy1_e60", o_busy[1], 1);
    go_edge(61); chk("rev_busy1_e61", o_busy[1], 0);
                 chk("rev_mapp1_e61", o_mapp[1], 0);
`ifdef CLK_MODE_SW_SWITCH_CNT_EN
                 chk("rev_cnt1_e61", o_cnt[15:8], 2);
`endif

    go_edge(65); mode[0] = 1'b1;
    go_edge(67); chk("idle_mapp0_e67", o_mapp[0], 0);
    go_edge(68); chk("idle_mapp0_e68", o_mapp[0], 1);
    go_edge(75); en[0] = 1'b1;
    go_edge(77); chk("idle_act0_e77", o_act[0], 0);
    go_edge(78); chk("idle_act0_e78", o_act[0], 1);
                 chk("idle_busy0_e78", o_busy[0], 0);
                 chk("idle_clk0_e78", o_clk[0], 1);
    go_edge(79); chk("idle_clk0_hi_e79", o_clk[0], 0);
    #5           chk("idle_clk0_lo_e79", o_clk[0], 1);

    go_edge(85); mode[1] = 1'b1;
    go_edge(88); chk("rsts_busy1_e88", o_busy[1], 1);
    go_edge(92); chk("rsts_mapp1_e92", o_mapp[1], 1);
    go_edge(94);
    #5 rstn = 1'b0;
    #1;
    chk("rsts_busy", o_busy, 0);
    chk("rsts_mapp", o_mapp, 0);
    chk("rsts_act", o_act, 3);
`ifdef CLK_MODE_SW_SWITCH_CNT_EN
    chk("rsts_cnt", o_cnt, 0);
`endif
    go_edge(96);
    #5 rstn = 1'b1;
    go_edge(97); chk("rsts_clk1_e97", o_clk[1], 1);
                 chk("rsts_mapp1_e97", o_mapp[1], 0);

    go_edge(115);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
